// File: rtl/seg_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_pkg
// Description : Shared definitions for the seven-segment scan decoder:
//               segment bit positions, hex glyph patterns and the
//               pattern-to-nibble decode function.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

  // Segment bit positions inside seg_select = {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam int NUM_DIGITS = 8;

  // Active-high glyphs for hex digits 0..F (segments g..a)
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
    GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
  };

  // Returns {valid, nibble}. Patterns outside the table (blank included)
  // decode to {0, 4'h0}.
  function automatic logic [4:0] seg7_to_hex(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH_TABLE[i]) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder_if
// Description : Bundle between the scanned display bus and the decoded
//               readback outputs.
//   bit_select   : digit enable, active-high, one-hot expected
//   seg_select   : segments {dp,g,f,e,d,c,b,a}, active-high
//   digit_code   : nibble k = decoded value of digit k
//   digit_valid  : bit k = digit k was a legal hex glyph
//   dp_out       : bit k = decimal point of digit k
//   frame_done   : one-cycle pulse when the outputs above update
//   bad_select   : sticky multi-hot bit_select flag
//   scan_timeout : no complete frame for the timeout window
//   master modport = display side / bench, slave modport = decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_decoder_if;

  logic [7:0]  bit_select;
  logic [7:0]  seg_select;
  logic [31:0] digit_code;
  logic [7:0]  digit_valid;
  logic [7:0]  dp_out;
  logic        frame_done;
  logic        bad_select;
  logic        scan_timeout;

  modport master (
    output bit_select,
    output seg_select,
    input  digit_code,
    input  digit_valid,
    input  dp_out,
    input  frame_done,
    input  bad_select,
    input  scan_timeout
  );

  modport slave (
    input  bit_select,
    input  seg_select,
    output digit_code,
    output digit_valid,
    output dp_out,
    output frame_done,
    output bad_select,
    output scan_timeout
  );

endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder_stable_filter.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_stable_filter
// Description : Registers the scan bus once, detects changes against the
//               previous sample and emits a single capture pulse per stable
//               run of STABLE_CYCLES identical samples.
//   clk_i, rst_i : clock, synchronous active-high reset
//   sel_i, seg_i : raw bit_select / seg_select pins
//   capture_o    : one-cycle pulse, sel_o/seg_o hold the stable pattern
//   sel_o, seg_o : the stable sample being captured
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_stable_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  input  wire logic [7:0] sel_i,
  input  wire logic [7:0] seg_i,
  output logic            capture_o,
  output logic [7:0]      sel_o,
  output logic [7:0]      seg_o
);

  localparam int             CW    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  C_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  C_HIT = CW'(STABLE_CYCLES - 1);

  logic [15:0]   in_q;
  logic [15:0]   prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != C_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_q   <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      in_q   <= {sel_i, seg_i};
      prev_q <= in_q;
      cnt_q  <= cnt_d;
    end
  end

  // The counter passes through C_HIT exactly once per run: it either
  // saturates at C_MAX or is cleared by a change. While cnt_q == C_HIT,
  // prev_q holds the value that has been stable for the whole run.
  assign capture_o = (cnt_q == C_HIT);
  assign sel_o     = prev_q[15:8];
  assign seg_o     = prev_q[7:0];

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Readback decoder for the multiplexed seven-segment display.
//               Filters the scan bus, decodes each stable digit into a
//               shadow frame and publishes complete frames atomically.
//   sys_clk  : system clock
//   sys_rst  : synchronous active-high reset
//   bus      : seg_scan_decoder_if slave (scan inputs, decoded outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int         STABLE_CYCLES  = 4,
  parameter logic [7:0] FRAME_MASK     = 8'hFF,
  parameter int         TIMEOUT_CYCLES = 200000
) (
  input  wire logic          sys_clk,
  input  wire logic          sys_rst,
  seg_scan_decoder_if.slave  bus
);

  localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

  // Filter outputs
  logic       cap;
  logic [7:0] cap_sel;
  logic [7:0] cap_seg;

  seg_scan_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .sel_i     (bus.bit_select),
    .seg_i     (bus.seg_select),
    .capture_o (cap),
    .sel_o     (cap_sel),
    .seg_o     (cap_seg)
  );

  // State
  logic [31:0]   shadow_code_q,  shadow_code_d;
  logic [7:0]    shadow_valid_q, shadow_valid_d;
  logic [7:0]    shadow_dp_q,    shadow_dp_d;
  logic [7:0]    seen_q,         seen_d;
  logic [31:0]   code_q;
  logic [7:0]    valid_q;
  logic [7:0]    dp_q;
  logic          done_q;
  logic          bad_q;
  logic [TW-1:0] tmo_q,          tmo_d;

  logic [4:0]    dec;
  logic          cap_one;
  logic          cap_multi;
  logic          complete;
  logic [31:0]   code_mask;

  // Expand the digit mask to nibble granularity for the output load.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_code_mask
    assign code_mask[4*k +: 4] = {4{FRAME_MASK[k]}};
  end

  assign dec       = seg7_to_hex(cap_seg[SEG_G:SEG_A]);
  assign cap_one   = cap && $onehot(cap_sel);
  assign cap_multi = cap && (cap_sel != 8'd0) && !$onehot(cap_sel);

  always_comb begin
    shadow_code_d  = shadow_code_q;
    shadow_valid_d = shadow_valid_q;
    shadow_dp_d    = shadow_dp_q;
    seen_d         = seen_q;
    if (cap_one) begin
      seen_d = seen_q | cap_sel;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap_sel[k]) begin
          shadow_code_d[4*k +: 4] = dec[3:0];
          shadow_valid_d[k]       = dec[4];
          shadow_dp_d[k]          = cap_seg[SEG_DP];
        end
      end
    end
  end

  // Gated by a capture so that an empty mask cannot fire every cycle.
  assign complete = cap_one && ((seen_d & FRAME_MASK) == FRAME_MASK);

  always_comb begin
    tmo_d = tmo_q;
    if (complete) begin
      tmo_d = '0;
    end else if (tmo_q != T_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shadow_code_q  <= '0;
      shadow_valid_q <= '0;
      shadow_dp_q    <= '0;
      seen_q         <= '0;
      code_q         <= '0;
      valid_q        <= '0;
      dp_q           <= '0;
      done_q         <= 1'b0;
      bad_q          <= 1'b0;
      tmo_q          <= '0;
    end else begin
      shadow_code_q  <= shadow_code_d;
      shadow_valid_q <= shadow_valid_d;
      shadow_dp_q    <= shadow_dp_d;
      // The completing capture is already folded into the output load,
      // so the mask restarts empty for the next frame.
      seen_q         <= complete ? 8'd0 : seen_d;
      done_q         <= complete;
      bad_q          <= bad_q | cap_multi;
      tmo_q          <= tmo_d;
      if (complete) begin
        code_q  <= shadow_code_d  & code_mask;
        valid_q <= shadow_valid_d & FRAME_MASK;
        dp_q    <= shadow_dp_d    & FRAME_MASK;
      end
    end
  end

  assign bus.digit_code   = code_q;
  assign bus.digit_valid  = valid_q;
  assign bus.dp_out       = dp_q;
  assign bus.frame_done   = done_q;
  assign bus.bad_select   = bad_q;
  assign bus.scan_timeout = (tmo_q >= T_MAX);

endmodule
`default_nettype wire
